// File: rtl/fsm_seq_detect.sv
// fsm_seq_detect: parametrised serial pattern detector with overlap control and match counter
//   Build option: define FSM_SEQ_DETECT_SAT_EN to make match_count saturate instead of wrap.
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   in_valid    qualifies in this cycle
//   in          serial data bit
//   match       one-cycle registered detect pulse
//   state       IDLE=0, FILL=1, RUN=2
//   fill        valid bits in history, saturates at W
//   history     last W bits received, newest at LSB
//   match_count matches since reset
module fsm_seq_detect #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in,
    output logic                     match,
    output logic [1:0]               state,
    output logic [$clog2(W+1)-1:0]   fill,
    output logic [W-1:0]             history,
    output logic [CNT_W-1:0]         match_count
);
    localparam int FW = $clog2(W + 1);
    localparam logic [FW-1:0] FULL = FW'(W);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
    state_t st, st_n;
    logic [FW-1:0] fill_inc, fill_n;
    logic [W-1:0] hist_n;
    logic [CNT_W-1:0] cnt_n;
    logic hit;
    assign state = st;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st          <= IDLE;
            fill        <= '0;
            history     <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            st          <= st_n;
            fill        <= fill_n;
            history     <= hist_n;
            match       <= hit;
            match_count <= cnt_n;
        end
    end
    always_comb begin
        hist_n   = in_valid ? {history[W-2:0], in} : history;
        fill_inc = (fill == FULL) ? FULL : fill + FW'(1);
        // fill gating keeps the all-zero reset history from matching PATTERN=0
        hit      = in_valid && (fill_inc == FULL) && (hist_n == PATTERN);
        fill_n   = fill;
        st_n     = st;
        if (in_valid) begin
            // non-overlapping mode restarts the window; history itself keeps shifting
            fill_n = (hit && !OVERLAP) ? '0 : fill_inc;
            st_n   = (hit && !OVERLAP) ? IDLE : ((fill_inc == FULL) ? RUN : FILL);
        end
`ifdef FSM_SEQ_DETECT_SAT_EN
        cnt_n = (hit && match_count != '1) ? match_count + CNT_W'(1) : match_count;
`else
        cnt_n = hit ? match_count + CNT_W'(1) : match_count;
`endif
    end
endmodule

// File: tb/tb_fsm_seq_detect.sv
// tb_fsm_seq_detect: directed and random checks of four detector configurations against a window model
module tb_fsm_seq_detect;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in = 1'b0;
    logic [3:0]       m;
    logic [3:0][1:0]  st;
    logic [3:0][2:0]  fl;
    logic [3:0][3:0]  hi;
    logic [2:0][7:0]  mc;
    logic [1:0]       mc3;
    int nchk = 0;
    int nerr = 0;
    int pat[4] = '{11, 11, 0, 11};
    bit ov[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    int cw[4]  = '{8, 8, 8, 2};
    int fillm[4], histm[4], cntm[4], matchm[4];

    always #5 clk = ~clk;

    fsm_seq_detect #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) d_ov (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .match(m[0]),
        .state(st[0]), .fill(fl[0]), .history(hi[0]), .match_count(mc[0]));
    fsm_seq_detect #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) d_no (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .match(m[1]),
        .state(st[1]), .fill(fl[1]), .history(hi[1]), .match_count(mc[1]));
    fsm_seq_detect #(.W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8)) d_zero (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .match(m[2]),
        .state(st[2]), .fill(fl[2]), .history(hi[2]), .match_count(mc[2]));
    fsm_seq_detect #(.W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) d_cnt (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in), .match(m[3]),
        .state(st[3]), .fill(fl[3]), .history(hi[3]), .match_count(mc3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_count(input int k);
        int top = (1 << cw[k]) - 1;
`ifdef FSM_SEQ_DETECT_SAT_EN
        return (cntm[k] > top) ? top : cntm[k];
`else
        return cntm[k] % (top + 1);
`endif
    endfunction

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("match%0d", k), 32'(m[k]), 32'(matchm[k]));
            check($sformatf("fill%0d", k), 32'(fl[k]), 32'(fillm[k]));
            check($sformatf("history%0d", k), 32'(hi[k]), 32'(histm[k]));
            check($sformatf("state%0d", k), 32'(st[k]),
                  (fillm[k] == 0) ? 32'd0 : (fillm[k] == 4) ? 32'd2 : 32'd1);
            check($sformatf("count%0d", k), (k == 3) ? 32'(mc3) : 32'(mc[k]), 32'(exp_count(k)));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            fillm[k] = 0; histm[k] = 0; cntm[k] = 0; matchm[k] = 0;
        end
    endtask

    // sliding window of the last four bits; a match needs four bits since the last restart
    task automatic model_step(input logic v, input logic b);
        for (int k = 0; k < 4; k++) begin
            matchm[k] = 0;
            if (v) begin
                histm[k] = (histm[k] * 2 + int'(b)) % 16;
                fillm[k] = (fillm[k] < 4) ? fillm[k] + 1 : 4;
                if (fillm[k] == 4 && histm[k] == pat[k]) begin
                    matchm[k] = 1;
                    cntm[k]++;
                    if (!ov[k]) fillm[k] = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic v, input logic b);
        in_valid = v;
        in = b;
        @(posedge clk);
        model_step(v, b);
        #1 check_all();
    endtask

    // asynchronous assert mid-cycle, held over one edge with a valid bit present, released after it
    task automatic do_reset();
        in_valid = 1'b1;
        in = 1'b1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] s7;
        logic [15:0] s16;
        model_reset();
        @(posedge clk);
        #1 check_all();
        reset = 1'b0;
        s7 = 7'b1011011;
        for (int i = 6; i >= 0; i--) cycle(1'b1, s7[i]);
        cycle(1'b0, 1'b1);
        check("ov_total", 32'(mc[0]), 32'd2);
        check("no_fill_end", 32'(fl[1]), 32'd3);
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            cycle(1'b1, s7[i]);
            for (int g = 0; g < 3; g++) cycle(1'b0, ~s7[i]);
        end
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
        check("zero_total", 32'(mc[2]), 32'd5);
        do_reset();
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        @(negedge clk);
        do_reset();
        cycle(1'b1, 1'b1);
        check("rst_hist", 32'(hi[0]), 32'd1);
        do_reset();
        s16 = 16'b1011011011011011;
        for (int i = 15; i >= 0; i--) cycle(1'b1, s16[i]);
        check("pulses5", 32'(cntm[3]), 32'd5);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
